morse_receiver: RTL
===================

Name: morse_receiver

Overview:
- Receive-side counterpart of the Morse transmitter: samples one keyed line (the GPIO Morse output bit) and measures mark and space durations in clock cycles.
- Classifies each mark as dot or dash and groups symbols into characters by gap length.
- Emits the ASCII code of each character, plus 0x20 for a word gap, through a one-entry valid/ready output register.
- Sits next to the processor on the board and loops back the transmitter for self-test.

Parameters:
- UNIT_CYCLES, 16: clock cycles in one Morse time unit (one dot). Minimum value is 2.
- CNT_W, 8: width of the duration counter. It must hold 7*UNIT_CYCLES.
- GLITCH_CYCLES, 3: cycles the input must stay stable to be accepted. Used only with the optional feature.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- morse_in  input  1  asynchronous keyed line; 1 = mark (tone on).
- char_ready  input  1  consumer accepts char_data when char_valid=1.
- char_data  output  8  ASCII code of the decoded character.
- char_valid  output  1  char_data is held valid until accepted.
- overrun  output  1  sticky flag: a character was dropped because the output register was full.

Behaviour:
- Clock, reset and input sampling:
  - One clock (CLK). Reset is synchronous and active-high.
  - morse_in passes through a 2-FF synchronizer, giving signal line_s with 2 cycles of latency. All timing below refers to line_s edges.
- Reset:
  - State goes to IDLE; the counter, symbol register and length are cleared.
  - Outputs after reset: char_data=0x00, char_valid=0, overrun=0.
  - A Reset asserted mid-mark or mid-character discards all partial symbols. No character is emitted.
- Symbol storage:
  - sym is a 6-bit register holding one bit per symbol; dot=0, dash=1.
  - Each new symbol is shifted in at bit 0, so the first-received symbol is the most significant of the len bits.
  - len is a 3-bit symbol count, 0 to 7, and saturates at 7.
- Counter: cnt saturates at 7*UNIT_CYCLES.
- State machine:
  - IDLE: line low, nothing pending. On a line_s rising edge: cnt<=1, go to MARK.
  - MARK: cnt increments every cycle while line_s=1. On the falling edge the mark is classified:
    - cnt < 2*UNIT_CYCLES is a dot; otherwise it is a dash.
    - The symbol is shifted in, len increments, then cnt<=1 and the state goes to SPACE.
  - SPACE: cnt increments while line_s=0.
    - Rising edge before cnt reaches 2*UNIT_CYCLES: intra-character gap. cnt<=1, go to MARK.
    - In the cycle cnt reaches 2*UNIT_CYCLES: emit the decoded character, clear sym and len, go to WORD_WAIT. Counting continues.
  - WORD_WAIT: cnt continues counting.
    - Rising edge before cnt reaches 5*UNIT_CYCLES: cnt<=1, go to MARK.
    - In the cycle cnt reaches 5*UNIT_CYCLES: emit 0x20, go to IDLE.
- Decode:
  - Combinational table of ITU patterns for A–Z (0x41–0x5A) and 0–9 (0x30–0x39).
  - Any other pattern, or len=7 (more than 6 symbols), decodes to 0x3F ('?').
- Output register:
  - An emit loads char_data and sets char_valid=1 in the next cycle.
  - A transfer occurs when char_valid=1 and char_ready=1; char_valid clears in the next cycle unless a new emit occurs in the same cycle.
  - An emit in the same cycle as a transfer is loaded, with no overrun.
  - An emit while char_valid=1 and char_ready=0 drops the new code, keeps the held code and sets overrun=1. overrun clears only on Reset.
- Latency: from the synchronized falling edge of the last mark to char_valid is 2*UNIT_CYCLES+1 cycles.

Optional Feature:
- Macro: MORSE_GLITCH_FILTER_EN.
- When defined:
  - line_s changes only after the synchronizer output has held a new value for GLITCH_CYCLES consecutive cycles.
  - Shorter pulses of either polarity are ignored.
  - Latency grows by GLITCH_CYCLES.
- When undefined: line_s is the raw 2-FF synchronizer output, and any single-cycle pulse counts as a mark or space.

Test Plan:
- UNIT_CYCLES=4. Mark 4 cycles, then low 30 cycles, char_ready=1 → char_data=0x45 ('E') valid 9 cycles after the falling edge, then 0x20 at cnt=20.
- Mark 4, space 4, mark 12, space 10 → 0x41 ('A'). No character is emitted during the 4-cycle space.
- Dot/dash boundary:
  - A 7-cycle mark followed by a long space → 0x45.
  - An 8-cycle mark followed by a long space → 0x54 ('T').
- Five dots → 0x35 ('5'). Seven dots → 0x3F. Pattern dot-dot-dash-dash → 0x3F.
- char_ready=0 and two characters 'E', 'T' sent → char_data stays 0x45 and overrun=1. Raising char_ready then gives one transfer and char_valid=0.
- Reset asserted after 2 symbols of 'S' → no output, char_valid=0, state IDLE. The next 'E' decodes correctly. With MORSE_GLITCH_FILTER_EN, a 2-cycle pulse is ignored.

Source files
------------

// File: rtl/morse_receiver.sv
// morse_receiver: decodes a keyed Morse line into ASCII characters.
//
// The line is synchronized and then timed in clock cycles. A mark is a dot when
// it is shorter than 2 units and a dash otherwise. A gap of 2 units ends the
// character, and a gap of 5 units ends the word. Characters go out through a
// one-entry valid/ready register. A word gap emits 0x20.
//
// Parameters:
//   UNIT_CYCLES   - clock cycles per Morse unit (>= 2)
//   CNT_W         - duration counter width, must hold 7*UNIT_CYCLES
//   GLITCH_CYCLES - stability window of the optional input glitch filter
//
// Ports:
//   CLK        in   system clock, rising edge
//   Reset      in   synchronous active-high reset
//   morse_in   in   asynchronous keyed line, 1 = mark
//   char_ready in   consumer accepts char_data while char_valid=1
//   char_data  out  ASCII code of the decoded character
//   char_valid out  char_data valid, held until accepted
//   overrun    out  sticky: a character was dropped because the register was full
//
// Build option: define MORSE_GLITCH_FILTER_EN to ignore line pulses shorter
// than GLITCH_CYCLES. This adds GLITCH_CYCLES cycles of latency.

module morse_receiver #(
    parameter int UNIT_CYCLES   = 16,
    parameter int CNT_W         = 8,
    parameter int GLITCH_CYCLES = 3
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       morse_in,
    input  logic       char_ready,
    output logic [7:0] char_data,
    output logic       char_valid,
    output logic       overrun
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] MARK      = 2'd1;
    localparam logic [1:0] SPACE     = 2'd2;
    localparam logic [1:0] WORD_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CHAR_GAP = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_GAP = CNT_W'(5 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(7 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Two-flop synchronizer on the asynchronous line
    logic sync1, sync2;
    logic line_s;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= morse_in;
            sync2 <= sync1;
        end
    end

`ifdef MORSE_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_CYCLES + 1);

    logic          line_f;
    logic [GW-1:0] glitch_cnt;

    // line_f follows sync2 only after sync2 has differed from it for
    // GLITCH_CYCLES consecutive cycles
    always_ff @(posedge CLK) begin
        if (Reset) begin
            line_f     <= 1'b0;
            glitch_cnt <= '0;
        end else if (sync2 == line_f) begin
            glitch_cnt <= '0;
        end else if (glitch_cnt == GW'(GLITCH_CYCLES - 1)) begin
            line_f     <= sync2;
            glitch_cnt <= '0;
        end else begin
            glitch_cnt <= glitch_cnt + GW'(1);
        end
    end

    assign line_s = line_f;
`else
    logic unused_glitch_cycles;
    assign unused_glitch_cycles = ^GLITCH_CYCLES;
    assign line_s = sync2;
`endif

    logic [1:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
    logic [5:0]       sym, sym_d;
    logic [2:0]       len, len_d;
    logic             emit;
    logic [7:0]       emit_code;
    logic [7:0]       dec;

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    // ITU table. The first symbol received is the MSB of the len valid bits.
    always_comb begin
        dec = 8'h3F;
        case (len)
            3'd1: dec = sym[0] ? 8'h54 : 8'h45;
            3'd2: begin
                case (sym[1:0])
                    2'b00:   dec = 8'h49;
                    2'b01:   dec = 8'h41;
                    2'b10:   dec = 8'h4E;
                    default: dec = 8'h4D;
                endcase
            end
            3'd3: begin
                case (sym[2:0])
                    3'b000:  dec = 8'h53;
                    3'b001:  dec = 8'h55;
                    3'b010:  dec = 8'h52;
                    3'b011:  dec = 8'h57;
                    3'b100:  dec = 8'h44;
                    3'b101:  dec = 8'h4B;
                    3'b110:  dec = 8'h47;
                    default: dec = 8'h4F;
                endcase
            end
            3'd4: begin
                case (sym[3:0])
                    4'b0000: dec = 8'h48;
                    4'b0001: dec = 8'h56;
                    4'b0010: dec = 8'h46;
                    4'b0100: dec = 8'h4C;
                    4'b0110: dec = 8'h50;
                    4'b0111: dec = 8'h4A;
                    4'b1000: dec = 8'h42;
                    4'b1001: dec = 8'h58;
                    4'b1010: dec = 8'h43;
                    4'b1011: dec = 8'h59;
                    4'b1100: dec = 8'h5A;
                    4'b1101: dec = 8'h51;
                    default: dec = 8'h3F;
                endcase
            end
            3'd5: begin
                case (sym[4:0])
                    5'b01111: dec = 8'h31;
                    5'b00111: dec = 8'h32;
                    5'b00011: dec = 8'h33;
                    5'b00001: dec = 8'h34;
                    5'b00000: dec = 8'h35;
                    5'b10000: dec = 8'h36;
                    5'b11000: dec = 8'h37;
                    5'b11100: dec = 8'h38;
                    5'b11110: dec = 8'h39;
                    5'b11111: dec = 8'h30;
                    default:  dec = 8'h3F;
                endcase
            end
            default: dec = 8'h3F;
        endcase
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        sym_d     = sym;
        len_d     = len;
        emit      = 1'b0;
        emit_code = dec;
        case (state)
            IDLE: begin
                if (line_s) begin
                    cnt_d   = CNT_ONE;
                    state_d = MARK;
                end
            end
            MARK: begin
                if (line_s) begin
                    cnt_d = cnt_inc;
                end else begin
                    sym_d   = {sym[4:0], cnt >= DASH_MIN};
                    len_d   = (len == 3'd7) ? len : len + 3'd1;
                    cnt_d   = CNT_ONE;
                    state_d = SPACE;
                end
            end
            SPACE: begin
                if (cnt >= CHAR_GAP) begin
                    emit      = 1'b1;
                    emit_code = dec;
                    sym_d     = '0;
                    len_d     = '0;
                    // A mark starting in the emit cycle is not lost
                    if (line_s) begin
                        cnt_d   = CNT_ONE;
                        state_d = MARK;
                    end else begin
                        cnt_d   = cnt_inc;
                        state_d = WORD_WAIT;
                    end
                end else if (line_s) begin
                    cnt_d   = CNT_ONE;
                    state_d = MARK;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                if (cnt >= WORD_GAP) begin
                    emit      = 1'b1;
                    emit_code = 8'h20;
                    if (line_s) begin
                        cnt_d   = CNT_ONE;
                        state_d = MARK;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (line_s) begin
                    cnt_d   = CNT_ONE;
                    state_d = MARK;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            sym   <= '0;
            len   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            sym   <= sym_d;
            len   <= len_d;
        end
    end

    // One-entry output register. An emit may replace a code that is
    // transferring in the same cycle. Otherwise a full register drops it.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            char_data  <= 8'h00;
            char_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (emit) begin
            if (!char_valid || char_ready) begin
                char_data  <= emit_code;
                char_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (char_valid && char_ready) begin
            char_valid <= 1'b0;
        end
    end

endmodule
